// File: rtl/ising_config_pkg.sv
// Shared constants for the Ising machine controller: GPIO register map,
// instruction opcodes, sequencer state encoding and DAC channel indices.
package ising_config;

  localparam int DEF_INSTR_FIFO_DEPTH = 10;
  localparam int NUM_CH               = 7;

  localparam logic [15:0] ADDR_INSTR_B_SEL = 16'h0000;
  localparam logic [15:0] ADDR_RUN         = 16'h0001;
  localparam logic [15:0] ADDR_CLEAR       = 16'h0002;

  localparam logic [3:0] OP_HALT    = 4'h0;
  localparam logic [3:0] OP_SET     = 4'h1;
  localparam logic [3:0] OP_WAIT    = 4'h2;
  localparam logic [3:0] OP_CAPTURE = 4'h3;
  localparam logic [3:0] OP_FEED    = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] CH_A      = 3'd0;
  localparam logic [2:0] CH_B      = 3'd1;
  localparam logic [2:0] CH_C      = 3'd2;
  localparam logic [2:0] CH_A_NL   = 3'd3;
  localparam logic [2:0] CH_PHI_LO = 3'd4;
  localparam logic [2:0] CH_PHI    = 3'd5;
  localparam logic [2:0] CH_SMALLA = 3'd6;
  localparam logic [2:0] CH_NOP    = 3'd7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO, 2**AW entries: pop_dat_o is the head word whenever !empty_o.
// Push while full and pop while empty are ignored; clr_i flushes and wins over push/pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/experiment_top_level_wrapper.sv
// Ising machine control top: GPIO register port, DMA-loaded instruction/beta FIFOs, sequencer
// driving seven DAC streams. ISING_ADC_READBACK_EN exposes mac/nl on gpio_out_bus[31:16].
module experiment_top_level_wrapper
  import ising_config::*;
#(
  parameter int INSTR_FIFO_DEPTH = DEF_INSTR_FIFO_DEPTH,
  parameter int WAVE_POS         = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  gpio_in,
  output logic [31:0]  gpio_out_bus,
  output logic [255:0] m0_axis_tdata,
  output logic         m0_axis_tvalid,
  input  logic         m0_axis_tready,
  output logic [255:0] m1_axis_tdata,
  output logic         m1_axis_tvalid,
  input  logic         m1_axis_tready,
  output logic [255:0] m2_axis_tdata,
  output logic         m2_axis_tvalid,
  input  logic         m2_axis_tready,
  output logic [255:0] m3_axis_tdata,
  output logic         m3_axis_tvalid,
  input  logic         m3_axis_tready,
  output logic [255:0] m4_axis_tdata,
  output logic         m4_axis_tvalid,
  input  logic         m4_axis_tready,
  output logic [255:0] m5_axis_tdata,
  output logic         m5_axis_tvalid,
  input  logic         m5_axis_tready,
  output logic [255:0] m6_axis_tdata,
  output logic         m6_axis_tvalid,
  input  logic         m6_axis_tready,
  input  logic [127:0] s0_axis_tdata,
  input  logic         s0_axis_tvalid,
  output logic         s0_axis_tready,
  input  logic [127:0] s1_axis_tdata,
  input  logic         s1_axis_tvalid,
  output logic         s1_axis_tready,
  input  logic [15:0]  s2_axis_tdata,
  input  logic         s2_axis_tvalid,
  output logic         s2_axis_tready
);

`ifdef ISING_ADC_READBACK_EN
  localparam int SEL_W = 2;
`else
  localparam int SEL_W = 1;
`endif

  logic             wclk_s1_q, wclk_s2_q, wclk_prev_q, out_en_q;
  logic             wr_stb, clear_d;
  logic [15:0]      wr_addr;
  logic [7:0]       wr_data;
  logic [SEL_W-1:0] sel_q;
  state_e           state_q;
  logic [15:0]      instr_q, mac_q, nl_q, readback;
  logic [11:0]      wait_cnt_q;
  logic [15:0]      ch_q [NUM_CH];
  logic             instr_ovf_q, beta_ovf_q;
  logic             instr_push, beta_push, instr_pop, beta_pop;
  logic             instr_full, instr_empty, beta_full, beta_empty, sel_full;
  logic [15:0]      instr_rd, beta_rd;
  logic [3:0]       opcode;
  logic [2:0]       op_ch;
  logic             unused_ok;

  // w_clk is asynchronous to clk: two-flop synchronizer, then rising-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wclk_s1_q   <= 1'b0;
      wclk_s2_q   <= 1'b0;
      wclk_prev_q <= 1'b0;
      out_en_q    <= 1'b0;
    end else begin
      wclk_s1_q   <= gpio_in[24];
      wclk_s2_q   <= wclk_s1_q;
      wclk_prev_q <= wclk_s2_q;
      out_en_q    <= 1'b1;
    end
  end

  assign wr_stb  = wclk_s2_q && !wclk_prev_q;
  assign wr_addr = gpio_in[15:0];
  assign wr_data = gpio_in[23:16];
  assign clear_d = wr_stb && (wr_addr == ADDR_CLEAR);

  assign sel_full       = sel_q[0] ? beta_full : instr_full;
  assign s2_axis_tready = out_en_q && !sel_full;
  assign instr_push     = s2_axis_tvalid && s2_axis_tready && !sel_q[0];
  assign beta_push      = s2_axis_tvalid && s2_axis_tready && sel_q[0];

  assign opcode    = instr_q[15:12];
  assign op_ch     = instr_q[2:0];
  assign instr_pop = (state_q == ST_FETCH);
  assign beta_pop  = (state_q == ST_EXEC) && (opcode == OP_SET);

  sync_fifo #(.WIDTH(16), .AW(INSTR_FIFO_DEPTH)) u_instr_fifo (
    .clk(clk), .rst_n(rst), .clr_i(clear_d),
    .push_i(instr_push), .push_dat_i(s2_axis_tdata),
    .pop_i(instr_pop), .pop_dat_o(instr_rd),
    .full_o(instr_full), .empty_o(instr_empty)
  );

  sync_fifo #(.WIDTH(16), .AW(INSTR_FIFO_DEPTH)) u_beta_fifo (
    .clk(clk), .rst_n(rst), .clr_i(clear_d),
    .push_i(beta_push), .push_dat_i(s2_axis_tdata),
    .pop_i(beta_pop), .pop_dat_o(beta_rd),
    .full_o(beta_full), .empty_o(beta_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      wait_cnt_q  <= '0;
      mac_q       <= '0;
      nl_q        <= '0;
      sel_q       <= '0;
      instr_ovf_q <= 1'b0;
      beta_ovf_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
    end else begin
      if (s2_axis_tvalid && out_en_q && sel_full) begin
        if (sel_q[0]) beta_ovf_q  <= 1'b1;
        else          instr_ovf_q <= 1'b1;
      end
      case (state_q)
        ST_FETCH: begin
          if (instr_empty) begin
            state_q <= ST_DONE;
          end else begin
            instr_q <= instr_rd;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_HALT: state_q <= ST_DONE;
            OP_SET: begin
              // Stall here until the DMA delivers a beta word.
              if (!beta_empty) begin
                if (op_ch != CH_NOP) ch_q[op_ch] <= beta_rd;
                state_q <= ST_FETCH;
              end
            end
            OP_WAIT: begin
              wait_cnt_q <= instr_q[11:0];
              state_q    <= ST_WAIT;
            end
            OP_CAPTURE: begin
              if (s0_axis_tvalid) mac_q <= s0_axis_tdata[16*WAVE_POS +: 16];
              if (s1_axis_tvalid) nl_q  <= s1_axis_tdata[16*WAVE_POS +: 16];
              state_q <= ST_FETCH;
            end
            OP_FEED: begin
              if (op_ch != CH_NOP) ch_q[op_ch] <= instr_q[3] ? nl_q : mac_q;
              state_q <= ST_FETCH;
            end
            default: state_q <= ST_FETCH;
          endcase
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) state_q <= ST_FETCH;
          else                  wait_cnt_q <= wait_cnt_q - 12'd1;
        end
        default: ;
      endcase
      // Register writes land last so they override the sequencer in the same cycle.
      if (wr_stb) begin
        if (wr_addr == ADDR_INSTR_B_SEL) sel_q <= wr_data[SEL_W-1:0];
        if (wr_addr == ADDR_RUN) begin
          if (!wr_data[0])                                   state_q <= ST_IDLE;
          else if (state_q == ST_IDLE || state_q == ST_DONE) state_q <= ST_FETCH;
        end
        if (clear_d) begin
          state_q     <= ST_IDLE;
          instr_ovf_q <= 1'b0;
          beta_ovf_q  <= 1'b0;
          for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
        end
      end
    end
  end

`ifdef ISING_ADC_READBACK_EN
  assign readback = sel_q[1] ? nl_q : mac_q;
`else
  assign readback = '0;
`endif

  assign gpio_out_bus = {readback, 9'd0, beta_empty, instr_empty, beta_ovf_q, instr_ovf_q, state_q};

  assign m0_axis_tdata = {16{ch_q[CH_A]}};
  assign m1_axis_tdata = {16{ch_q[CH_B]}};
  assign m2_axis_tdata = {16{ch_q[CH_C]}};
  assign m3_axis_tdata = {16{ch_q[CH_A_NL]}};
  assign m4_axis_tdata = {16{ch_q[CH_PHI_LO]}};
  assign m5_axis_tdata = {16{ch_q[CH_PHI]}};
  assign m6_axis_tdata = {16{ch_q[CH_SMALLA]}};

  assign m0_axis_tvalid = out_en_q;
  assign m1_axis_tvalid = out_en_q;
  assign m2_axis_tvalid = out_en_q;
  assign m3_axis_tvalid = out_en_q;
  assign m4_axis_tvalid = out_en_q;
  assign m5_axis_tvalid = out_en_q;
  assign m6_axis_tvalid = out_en_q;
  assign s0_axis_tready = out_en_q;
  assign s1_axis_tready = out_en_q;

  assign unused_ok = ^{gpio_in[31:25], wr_data, m0_axis_tready, m1_axis_tready, m2_axis_tready,
                       m3_axis_tready, m4_axis_tready, m5_axis_tready, m6_axis_tready,
                       s0_axis_tdata, s1_axis_tdata};

endmodule

// File: tb/tb_experiment_top_level_wrapper.sv
// Directed bench for experiment_top_level_wrapper: program execution, GPIO latency, WAIT timing,
// capture/feed, FIFO overflow and clear, SET stall, abort, and asynchronous reset.
module tb_experiment_top_level_wrapper;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  gpio_in = '0;
  logic [31:0]  gpio_out_bus;
  logic [255:0] m_tdata [7];
  logic [6:0]   m_tvalid;
  logic [127:0] s0_tdata = '0, s1_tdata = '0;
  logic         s0_tvalid = 1'b0, s1_tvalid = 1'b0, s0_tready, s1_tready;
  logic [15:0]  s2_tdata = '0;
  logic         s2_tvalid = 1'b0, s2_tready;
  int           checks = 0, passed = 0;

  always #5 clk = ~clk;

  experiment_top_level_wrapper dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out_bus(gpio_out_bus),
    .m0_axis_tdata(m_tdata[0]), .m0_axis_tvalid(m_tvalid[0]), .m0_axis_tready(1'b1),
    .m1_axis_tdata(m_tdata[1]), .m1_axis_tvalid(m_tvalid[1]), .m1_axis_tready(1'b1),
    .m2_axis_tdata(m_tdata[2]), .m2_axis_tvalid(m_tvalid[2]), .m2_axis_tready(1'b1),
    .m3_axis_tdata(m_tdata[3]), .m3_axis_tvalid(m_tvalid[3]), .m3_axis_tready(1'b1),
    .m4_axis_tdata(m_tdata[4]), .m4_axis_tvalid(m_tvalid[4]), .m4_axis_tready(1'b1),
    .m5_axis_tdata(m_tdata[5]), .m5_axis_tvalid(m_tvalid[5]), .m5_axis_tready(1'b1),
    .m6_axis_tdata(m_tdata[6]), .m6_axis_tvalid(m_tvalid[6]), .m6_axis_tready(1'b1),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .s2_axis_tdata(s2_tdata), .s2_axis_tvalid(s2_tvalid), .s2_axis_tready(s2_tready)
  );

  task automatic gpio_raise(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); gpio_in = {8'h00, d, a};
    @(negedge clk); gpio_in[24] = 1'b1;
  endtask

  task automatic gpio_write(input logic [15:0] a, input logic [7:0] d);
    gpio_raise(a, d);
    repeat (4) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_s2(input logic [15:0] w);
    @(negedge clk); s2_tdata = w; s2_tvalid = 1'b1;
    @(negedge clk); s2_tvalid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st);
    int n = 0;
    while (gpio_out_bus[2:0] !== st && n < 6000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      checks++; if (m_tdata[k] !== 256'h0) $display("FAIL reset_tdata%0d: got %h want 0", k, m_tdata[k]); else passed++;
    end
    checks++; if (m_tvalid !== 7'h00) $display("FAIL reset_tvalid: got %h want 00", m_tvalid); else passed++;
    checks++; if ({s0_tready, s1_tready, s2_tready} !== 3'b000) $display("FAIL reset_tready: got %b want 000", {s0_tready, s1_tready, s2_tready}); else passed++;
    checks++; if (gpio_out_bus !== 32'h0000_0060) $display("FAIL reset_gpio: got %h want 00000060", gpio_out_bus); else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_tvalid !== 7'h7f) $display("FAIL run_tvalid: got %h want 7f", m_tvalid); else passed++;
    checks++; if ({s0_tready, s1_tready, s2_tready} !== 3'b111) $display("FAIL run_tready: got %b want 111", {s0_tready, s1_tready, s2_tready}); else passed++;
  endtask

  task automatic test_program();
    gpio_write(16'h0000, 8'h01);
    push_s2(16'h1234); push_s2(16'hABCD);
    gpio_write(16'h0000, 8'h00);
    push_s2(16'h1000); push_s2(16'h1005); push_s2(16'h0000);
    gpio_write(16'h0001, 8'h01);
    wait_state(3'd4);
    checks++; if (gpio_out_bus[15:0] !== 16'h0064) $display("FAIL prog_gpio: got %h want 0064", gpio_out_bus[15:0]); else passed++;
    checks++; if (m_tdata[0] !== {16{16'h1234}}) $display("FAIL prog_m0: got %h want 1234 x16", m_tdata[0]); else passed++;
    checks++; if (m_tdata[5] !== {16{16'hABCD}}) $display("FAIL prog_m5: got %h want abcd x16", m_tdata[5]); else passed++;
    checks++; if (m_tdata[1] !== 256'h0) $display("FAIL prog_m1_untouched: got %h want 0", m_tdata[1]); else passed++;
  endtask

  task automatic test_wait();
    int cnt;
    gpio_write(16'h0000, 8'h01);
    push_s2(16'h0042);
    gpio_write(16'h0000, 8'h00);
    push_s2(16'h2009); push_s2(16'h1001);
    gpio_raise(16'h0001, 8'h01);
    wait_state(3'd3);
    cnt = 0;
    while (gpio_out_bus[2:0] === 3'd3 && cnt < 100) begin cnt++; @(negedge clk); end
    checks++; if (cnt !== 10) $display("FAIL wait_cycles: got %0d want 10", cnt); else passed++;
    checks++; if (gpio_out_bus[2:0] !== 3'd1 || m_tdata[1] !== 256'h0) $display("FAIL wait_fetch: state %0d m1 %h want 1 and 0", gpio_out_bus[2:0], m_tdata[1][15:0]); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (m_tdata[1] !== {16{16'h0042}}) $display("FAIL wait_m1: got %h want 0042 x16", m_tdata[1]); else passed++;
    gpio_in[24] = 1'b0;
    wait_state(3'd4);
  endtask

  task automatic test_capture();
    for (int i = 0; i < 8; i++) begin
      s0_tdata[16*i +: 16] = 16'h0100 + 16'(i);
      s1_tdata[16*i +: 16] = 16'h0200 + 16'(i);
    end
    s0_tdata[64 +: 16] = 16'h0777;
    s1_tdata[64 +: 16] = 16'h0123;
    s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    push_s2(16'h3000); push_s2(16'h4006); push_s2(16'h400B);
    gpio_write(16'h0001, 8'h01);
    wait_state(3'd4);
    checks++; if (gpio_out_bus[2:0] !== 3'd4) $display("FAIL cap_state: got %0d want 4", gpio_out_bus[2:0]); else passed++;
    checks++; if (m_tdata[6] !== {16{16'h0777}}) $display("FAIL cap_m6: got %h want 0777 x16", m_tdata[6]); else passed++;
    checks++; if (m_tdata[3] !== {16{16'h0123}}) $display("FAIL cap_m3: got %h want 0123 x16", m_tdata[3]); else passed++;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_rb;
    for (int i = 0; i < 1024; i++) begin
      s2_tdata = 16'(i) & 16'h0FFF; s2_tvalid = 1'b1;
      @(negedge clk);
    end
    checks++; if (s2_tready !== 1'b0) $display("FAIL ovf_full_tready: got %b want 0", s2_tready); else passed++;
    checks++; if (gpio_out_bus[5:3] !== 3'b000) $display("FAIL ovf_pre_flags: got %b want 000", gpio_out_bus[5:3]); else passed++;
    s2_tdata = 16'hDEAD;
    @(negedge clk);
    s2_tvalid = 1'b0;
    checks++; if (gpio_out_bus[4:3] !== 2'b01) $display("FAIL ovf_flag: got %b want 01", gpio_out_bus[4:3]); else passed++;
    gpio_write(16'h0002, 8'h00);
    checks++; if (gpio_out_bus[15:0] !== 16'h0060) $display("FAIL clear_gpio: got %h want 0060", gpio_out_bus[15:0]); else passed++;
    checks++; if (s2_tready !== 1'b1) $display("FAIL clear_tready: got %b want 1", s2_tready); else passed++;
    checks++; if (m_tdata[6] !== 256'h0 || m_tdata[0] !== 256'h0) $display("FAIL clear_channels: got m6 %h m0 %h want 0", m_tdata[6][15:0], m_tdata[0][15:0]); else passed++;
`ifdef ISING_ADC_READBACK_EN
    exp_rb = 16'h0777;
`else
    exp_rb = 16'h0000;
`endif
    checks++; if (gpio_out_bus[31:16] !== exp_rb) $display("FAIL readback: got %h want %h", gpio_out_bus[31:16], exp_rb); else passed++;
  endtask

  task automatic test_stall();
    logic [2:0] seen [4];
    push_s2(16'h1002);
    gpio_raise(16'h0001, 8'h01);
    for (int i = 0; i < 4; i++) begin @(negedge clk); seen[i] = gpio_out_bus[2:0]; end
    gpio_in[24] = 1'b0;
    checks++; if (seen[0] !== 3'd0 || seen[1] !== 3'd0) $display("FAIL gpio_latency_early: got %0d %0d want 0 0", seen[0], seen[1]); else passed++;
    checks++; if (seen[2] !== 3'd1 || seen[3] !== 3'd2) $display("FAIL gpio_latency_apply: got %0d %0d want 1 2", seen[2], seen[3]); else passed++;
    gpio_write(16'h0000, 8'h01);
    checks++; if (gpio_out_bus[2:0] !== 3'd2) $display("FAIL stall_state: got %0d want 2", gpio_out_bus[2:0]); else passed++;
    push_s2(16'h0005);
    wait_state(3'd4);
    checks++; if (gpio_out_bus[6:0] !== 7'h64) $display("FAIL stall_done: got %h want 64", gpio_out_bus[6:0]); else passed++;
    checks++; if (m_tdata[2] !== {16{16'h0005}}) $display("FAIL stall_m2: got %h want 0005 x16", m_tdata[2]); else passed++;
  endtask

  task automatic test_abort_reset();
    gpio_write(16'h0000, 8'h00);
    push_s2(16'h2FFF); push_s2(16'h2FFF);
    gpio_write(16'h0001, 8'h01);
    wait_state(3'd3);
    checks++; if (gpio_out_bus[2:0] !== 3'd3) $display("FAIL abort_enter_wait: got %0d want 3", gpio_out_bus[2:0]); else passed++;
    gpio_write(16'h0001, 8'h00);
    checks++; if (gpio_out_bus[2:0] !== 3'd0) $display("FAIL abort_state: got %0d want 0", gpio_out_bus[2:0]); else passed++;
    checks++; if (m_tdata[2] !== {16{16'h0005}}) $display("FAIL abort_hold: got %h want 0005 x16", m_tdata[2]); else passed++;
    gpio_write(16'h0001, 8'h01);
    wait_state(3'd3);
    checks++; if (gpio_out_bus[2:0] !== 3'd3) $display("FAIL rerun_wait: got %0d want 3", gpio_out_bus[2:0]); else passed++;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (m_tdata[2] !== 256'h0 || m_tdata[1] !== 256'h0) $display("FAIL async_tdata: got m2 %h m1 %h want 0", m_tdata[2][15:0], m_tdata[1][15:0]); else passed++;
    checks++; if (m_tvalid !== 7'h00 || s0_tready !== 1'b0 || s2_tready !== 1'b0) $display("FAIL async_valid: got %h %b %b want 00 0 0", m_tvalid, s0_tready, s2_tready); else passed++;
    checks++; if (gpio_out_bus[2:0] !== 3'd0) $display("FAIL async_state: got %0d want 0", gpio_out_bus[2:0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_program();
    test_wait();
    test_capture();
    test_overflow();
    test_stall();
    test_abort_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
